// File: rtl/cnn_accel_udiv_11ns_5ns_seq.sv
// Unsigned restoring divider: quot = din0 / din1, rem = din0 % din1, one quotient bit per cycle.
// Latency: accept in cycle 0, ap_done in cycle din0_WIDTH+1; next accept no earlier than din0_WIDTH+2.
// Backpressure: ap_start is sampled only in IDLE and is never queued; hold it until ap_ready.
//
// Ports: ap_clk/ap_rst_n (synchronous active-low), ap_start/ap_ready/ap_idle/ap_done handshake,
//        din0/din1 operands (captured on accept), quot/rem results (held until the next ap_done).
// Optional: define CNN_ACCEL_UDIV_DBZ_FLAG_EN to add a registered div_by_zero output that is
//           updated together with quot/rem.
module cnn_accel_udiv_11ns_5ns_seq #(
    parameter int ID         = 1,
    parameter int din0_WIDTH = 11,
    parameter int din1_WIDTH = 5,
    parameter int quot_WIDTH = 11,
    parameter int rem_WIDTH  = 5
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  ap_start,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  ap_idle,
    output logic                  ap_ready,
    output logic                  ap_done,
    output logic [quot_WIDTH-1:0] quot,
    output logic [rem_WIDTH-1:0]  rem
`ifdef CNN_ACCEL_UDIV_DBZ_FLAG_EN
    ,
    output logic                  div_by_zero
`endif
);

    // The datapath relies on the result widths matching the operand widths.
    if (quot_WIDTH != din0_WIDTH || rem_WIDTH != din1_WIDTH || ID < 0) begin : g_bad_params
        $error("cnn_accel_udiv: quot/rem widths must match din0/din1 widths and ID must be >= 0");
    end

    localparam int PW = din1_WIDTH + 1;                              // partial remainder width
    localparam int CW = (din0_WIDTH > 1) ? $clog2(din0_WIDTH) : 1;   // iteration counter width

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q,   cnt_d;
    logic [din0_WIDTH-1:0] dvd_q,   dvd_d;   // dividend bits shift out the top, quotient bits shift in
    logic [din1_WIDTH-1:0] dvs_q,   dvs_d;
    logic [PW-1:0]         pr_q,    pr_d;
    logic                  dbz_q,   dbz_d;
    logic [quot_WIDTH-1:0] quot_q,  quot_d;
    logic [rem_WIDTH-1:0]  rem_q,   rem_d;

    logic [PW:0]           shifted;
    logic [PW:0]           trial;
    logic                  trial_ok;
    logic [PW-1:0]         pr_next;
    logic [din0_WIDTH-1:0] dvd_next;
    logic                  last_iter;

    // One restoring step. pr_q < divisor for a non-zero divisor, so the shifted value stays below
    // 2^PW and the top bit of the PW+1 bit difference is a valid sign bit.
    always_comb begin
        shifted   = {pr_q, dvd_q[din0_WIDTH-1]};
        trial     = shifted - {{(PW + 1 - din1_WIDTH){1'b0}}, dvs_q};
        trial_ok  = ~trial[PW];
        pr_next   = trial_ok ? trial[PW-1:0] : shifted[PW-1:0];
        dvd_next  = {dvd_q[din0_WIDTH-2:0], trial_ok};
        last_iter = (cnt_q == CW'(din0_WIDTH - 1));
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        pr_d    = pr_q;
        dbz_d   = dbz_q;
        quot_d  = quot_q;
        rem_d   = rem_q;

        unique case (state_q)
            S_IDLE: begin
                if (ap_start) begin
                    state_d = S_BUSY;
                    dvd_d   = din0;
                    dvs_d   = din1;
                    pr_d    = '0;
                    cnt_d   = '0;
                    dbz_d   = (din1 == '0);
                end
            end
            S_BUSY: begin
                dvd_d = dvd_next;
                pr_d  = pr_next;
                cnt_d = cnt_q + CW'(1);
                if (last_iter) begin
                    state_d = S_DONE;
                    // With a zero divisor the partial remainder just collects dividend bits, so its
                    // low bits already equal din0[din1_WIDTH-1:0]; only the quotient is forced.
                    quot_d  = dbz_q ? '1 : dvd_next;
                    rem_d   = pr_next[rem_WIDTH-1:0];
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            pr_q    <= '0;
            dbz_q   <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            pr_q    <= pr_d;
            dbz_q   <= dbz_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
        end
    end

`ifdef CNN_ACCEL_UDIV_DBZ_FLAG_EN
    logic dbz_flag_q, dbz_flag_d;

    // Published in the same edge as quot/rem so all three change together.
    always_comb begin
        dbz_flag_d = dbz_flag_q;
        if (state_q == S_BUSY && last_iter) begin
            dbz_flag_d = dbz_q;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            dbz_flag_q <= 1'b0;
        end else begin
            dbz_flag_q <= dbz_flag_d;
        end
    end

    assign div_by_zero = dbz_flag_q;
`endif

    assign ap_idle  = (state_q == S_IDLE);
    assign ap_ready = ap_start && (state_q == S_IDLE);
    assign ap_done  = (state_q == S_DONE);
    assign quot     = quot_q;
    assign rem      = rem_q;

endmodule

// File: tb/tb_cnn_accel_udiv_11ns_5ns_seq.sv
module tb_cnn_accel_udiv_11ns_5ns_seq;

    logic        ap_clk;
    logic        ap_rst_n;
    logic        ap_start;
    logic [10:0] din0;
    logic [4:0]  din1;
    logic        ap_idle;
    logic        ap_ready;
    logic        ap_done;
    logic [10:0] quot;
    logic [4:0]  rem;
`ifdef CNN_ACCEL_UDIV_DBZ_FLAG_EN
    logic        div_by_zero;
`endif

    int vectors;
    int miscompares;

    cnn_accel_udiv_11ns_5ns_seq #(
        .ID         (1),
        .din0_WIDTH (11),
        .din1_WIDTH (5),
        .quot_WIDTH (11),
        .rem_WIDTH  (5)
    ) dut (
        .ap_clk      (ap_clk),
        .ap_rst_n    (ap_rst_n),
        .ap_start    (ap_start),
        .din0        (din0),
        .din1        (din1),
        .ap_idle     (ap_idle),
        .ap_ready    (ap_ready),
        .ap_done     (ap_done),
        .quot        (quot),
        .rem         (rem)
`ifdef CNN_ACCEL_UDIV_DBZ_FLAG_EN
        ,
        .div_by_zero (div_by_zero)
`endif
    );

    initial begin
        ap_clk = 1'b0;
        forever #5 ap_clk = ~ap_clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Reference: plain integer division, with the divide-by-zero convention.
    function automatic logic [10:0] ref_q(input logic [10:0] a, input logic [4:0] b);
        return (b == 5'd0) ? 11'h7FF : 11'(a / b);
    endfunction

    function automatic logic [4:0] ref_r(input logic [10:0] a, input logic [4:0] b);
        return (b == 5'd0) ? a[4:0] : 5'(a % b);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one request from the post-edge point of cycle 0; returns at the post-edge point of
    // the first cycle after ap_done.
    task automatic run_div(input logic [10:0] a, input logic [4:0] b, input string tag);
        logic [10:0] hq;
        logic [4:0]  hr;
        bit          seen;
        hq = quot;
        hr = rem;
        din0 = a;
        din1 = b;
        ap_start = 1'b1;
        @(negedge ap_clk);
        chk({tag, ".ready"}, ap_ready, 1);
        @(posedge ap_clk); #1;
        ap_start = 1'b0;
        din0 = 11'($urandom);
        din1 = 5'($urandom);
        seen = 1'b0;
        for (int n = 1; n <= 20 && !seen; n++) begin
            @(negedge ap_clk);
            if (ap_done) begin
                seen = 1'b1;
                chk({tag, ".latency"}, n, 12);
                chk({tag, ".quot"}, quot, ref_q(a, b));
                chk({tag, ".rem"}, rem, ref_r(a, b));
`ifdef CNN_ACCEL_UDIV_DBZ_FLAG_EN
                chk({tag, ".dbz"}, div_by_zero, (b == 5'd0));
`endif
            end else begin
                chk({tag, ".hold_quot"}, quot, hq);
                chk({tag, ".hold_rem"}, rem, hr);
            end
            @(posedge ap_clk); #1;
        end
        chk({tag, ".done_seen"}, seen, 1);
    endtask

    initial begin
        int          acc_cyc[$];
        int          pend_cyc[$];
        logic [10:0] qa[$];
        logic [4:0]  qb[$];
        logic [10:0] hq, ea;
        logic [4:0]  hr, eb;
        int          ec;
        int          dones;
        bit          prev_done;

        vectors     = 0;
        miscompares = 0;
        ap_rst_n    = 1'b0;
        ap_start    = 1'b0;
        din0        = '0;
        din1        = '0;

        // Reset for three cycles, then check the idle state.
        repeat (3) @(posedge ap_clk);
        #1;
        ap_rst_n = 1'b1;
        @(negedge ap_clk);
        chk("rst.idle", ap_idle, 1);
        chk("rst.ready", ap_ready, 0);
        chk("rst.done", ap_done, 0);
        chk("rst.quot", quot, 0);
        chk("rst.rem", rem, 0);
        @(posedge ap_clk); #1;

        // Directed cases.
        run_div(11'd100, 5'd7, "basic");
        run_div(11'd2047, 5'd31, "max");
        run_div(11'd0, 5'd3, "zero_num");
        run_div(11'd30, 5'd31, "small");
        run_div(11'd31, 5'd1, "div1");
        run_div(11'd5, 5'd0, "dbz");
        run_div(11'd9, 5'd3, "after_dbz");
        run_div(11'd2047, 5'd0, "dbz_max");

        // Randomised cases, including an occasional zero divisor.
        for (int i = 0; i < 16; i++) begin
            logic [10:0] ra;
            logic [4:0]  rb;
            ra = 11'($urandom);
            rb = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
            run_div(ra, rb, "rand");
        end

        // ap_start held high with operands changing every cycle.
        hq = quot;
        hr = rem;
        dones = 0;
        prev_done = 1'b0;
        for (int c = 0; c < 42; c++) begin
            ap_start = (c < 39);
            din0 = 11'($urandom);
            din1 = 5'($urandom_range(0, 31));
            @(negedge ap_clk);
            if (ap_ready) begin
                acc_cyc.push_back(c);
                pend_cyc.push_back(c);
                qa.push_back(din0);
                qb.push_back(din1);
            end
            if (ap_done) begin
                dones++;
                chk("hs.single_pulse", prev_done, 0);
                if (qa.size() > 0) begin
                    ea = qa.pop_front();
                    eb = qb.pop_front();
                    ec = pend_cyc.pop_front();
                    chk("hs.done_cycle", c, ec + 12);
                    chk("hs.quot", quot, ref_q(ea, eb));
                    chk("hs.rem", rem, ref_r(ea, eb));
                end else begin
                    chk("hs.done_without_accept", ap_done, 0);
                end
                hq = quot;
                hr = rem;
            end else begin
                chk("hs.hold_quot", quot, hq);
                chk("hs.hold_rem", rem, hr);
            end
            prev_done = ap_done;
            @(posedge ap_clk); #1;
        end
        chk("hs.accepts", acc_cyc.size(), 3);
        chk("hs.dones", dones, 3);
        for (int i = 0; i < 3; i++) begin
            chk("hs.accept_cycle", (i < acc_cyc.size()) ? acc_cyc[i] : -1, i * 13);
        end

        // Reset in the middle of an operation.
        din0 = 11'd200;
        din1 = 5'd9;
        ap_start = 1'b1;
        @(negedge ap_clk);
        chk("midrst.ready", ap_ready, 1);
        @(posedge ap_clk); #1;
        ap_start = 1'b0;
        repeat (4) begin
            @(posedge ap_clk); #1;
        end
        ap_rst_n = 1'b0;
        @(posedge ap_clk); #1;
        ap_rst_n = 1'b1;
        @(negedge ap_clk);
        chk("midrst.idle", ap_idle, 1);
        chk("midrst.quot", quot, 0);
        chk("midrst.rem", rem, 0);
`ifdef CNN_ACCEL_UDIV_DBZ_FLAG_EN
        chk("midrst.dbz", div_by_zero, 0);
`endif
        for (int i = 0; i < 12; i++) begin
            chk("midrst.no_done", ap_done, 0);
            @(negedge ap_clk);
        end
        @(posedge ap_clk); #1;
        run_div(11'd200, 5'd9, "after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
